// File: rtl/lsu_stream_engine_pkg.sv
// Shared constants for the LSU stream engine: default widths and FSM state encodings.
package lsu_stream_engine_pkg;

  localparam int FE_ADDR_W = 32;
  localparam int FE_DATA_W = 32;

  typedef enum logic [1:0] {
    LSE_IDLE = 2'd0,
    LSE_RUN  = 2'd1,
    LSE_DONE = 2'd2
  } lse_state_e;

endpackage

// File: rtl/lsu_stream_engine_fifo.sv
// First-word-fall-through synchronous FIFO; a push and pop in the same cycle leave occupancy unchanged.
module lsu_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full FIFO accepts a push when popped; an empty one passes the pushed word straight through.
  assign w_do_push = push && (!full || pop);
  assign w_do_pop  = pop && (!empty || push);

  assign full     = (r_count == CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign count    = r_count;
  assign pop_data = empty ? push_data : r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + AW'(1);
      if (w_do_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/lsu_stream_engine.sv
// Strided load/store streaming engine: memory loads feed the accelerator through an input FIFO,
// accelerator results drain to memory through an output FIFO.
module lsu_stream_engine
  import lsu_stream_engine_pkg::*;
#(
  parameter int ADDR_W    = FE_ADDR_W,
  parameter int DATA_W    = FE_DATA_W,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_base_addr,
  input  logic [ADDR_W-1:0] load_stride,
  input  logic [ADDR_W-1:0] load_count,
  input  logic [ADDR_W-1:0] store_base_addr,
  input  logic [ADDR_W-1:0] store_stride,
  input  logic [ADDR_W-1:0] store_count,
  output logic              busy,
  output logic              done,
  output logic              load_req,
  output logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_complete,
  output logic              store_req,
  output logic [ADDR_W-1:0] store_addr,
  output logic [DATA_W-1:0] store_data,
  input  logic              store_complete,
  output logic              acc_in_valid,
  input  logic              acc_in_ready,
  output logic [DATA_W-1:0] acc_in_data,
  input  logic              acc_out_valid,
  output logic              acc_out_ready,
  input  logic [DATA_W-1:0] acc_out_data
);
  localparam int SHIFT = $clog2(DATA_W / 8);
  localparam int IN_CW = $clog2(IN_DEPTH) + 1;
  localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;
  localparam logic [IN_CW-1:0] IN_DEPTH_C = IN_CW'(IN_DEPTH);

  lse_state_e        r_state;
  lse_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_load_addr, r_load_step, r_load_count, r_loads_issued;
  logic [ADDR_W-1:0] r_store_addr, r_store_step, r_store_count, r_stores_done;
  logic [ADDR_W-1:0] r_results_rcvd;

  logic              w_running, w_flush;
  logic              w_load_fire, w_acc_in_fire, w_acc_out_fire, w_store_fire;
  logic [DATA_W-1:0] w_in_head, w_out_head;
  logic              w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic [IN_CW-1:0]  w_in_count;
  logic [OUT_CW-1:0] w_out_count;

  assign w_running = (r_state == LSE_RUN);

  // A pending load cannot grow the input FIFO, so the request stays asserted until it completes.
  assign load_req      = w_running && (r_loads_issued < r_load_count) && (w_in_count < IN_DEPTH_C);
  assign load_addr     = r_load_addr;
  assign acc_in_valid  = w_running && !w_in_empty;
  assign acc_in_data   = acc_in_valid ? w_in_head : '0;
  assign acc_out_ready = w_running && !w_out_full && (r_results_rcvd < r_store_count);
  assign store_req     = w_running && !w_out_empty;
  assign store_addr    = r_store_addr;
  assign store_data    = store_req ? w_out_head : '0;

  assign w_load_fire    = load_req && load_complete && !w_in_full;
  assign w_acc_in_fire  = acc_in_valid && acc_in_ready;
  assign w_acc_out_fire = acc_out_valid && acc_out_ready;
  assign w_store_fire   = store_req && store_complete;

  lsu_sync_fifo #(.WIDTH(DATA_W), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk(clk), .reset(reset), .flush(w_flush),
    .push(w_load_fire), .push_data(load_data),
    .pop(w_acc_in_fire), .pop_data(w_in_head),
    .full(w_in_full), .empty(w_in_empty), .count(w_in_count)
  );

  lsu_sync_fifo #(.WIDTH(DATA_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk(clk), .reset(reset), .flush(w_flush),
    .push(w_acc_out_fire), .push_data(acc_out_data),
    .pop(w_store_fire), .pop_data(w_out_head),
    .full(w_out_full), .empty(w_out_empty), .count(w_out_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      LSE_IDLE: if (start) w_state_nxt = LSE_RUN;
      LSE_RUN: begin
        busy = 1'b1;
        if ((r_stores_done == r_store_count) && (r_loads_issued == r_load_count) &&
            (w_out_count == '0))
          w_state_nxt = LSE_DONE;
      end
      LSE_DONE: begin
        done        = 1'b1;
        w_flush     = 1'b1;
        w_state_nxt = LSE_IDLE;
      end
      default: w_state_nxt = LSE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= LSE_IDLE;
      r_load_addr    <= '0;
      r_load_step    <= '0;
      r_load_count   <= '0;
      r_loads_issued <= '0;
      r_store_addr   <= '0;
      r_store_step   <= '0;
      r_store_count  <= '0;
      r_stores_done  <= '0;
      r_results_rcvd <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == LSE_IDLE) && start) begin
        r_load_addr    <= load_base_addr;
        r_load_step    <= load_stride << SHIFT;
        r_load_count   <= load_count;
        r_loads_issued <= '0;
        r_store_addr   <= store_base_addr;
        r_store_step   <= store_stride << SHIFT;
        r_store_count  <= store_count;
        r_stores_done  <= '0;
        r_results_rcvd <= '0;
      end else begin
        if (w_load_fire) begin
          r_load_addr    <= r_load_addr + r_load_step;
          r_loads_issued <= r_loads_issued + ADDR_W'(1);
        end
        if (w_acc_out_fire) r_results_rcvd <= r_results_rcvd + ADDR_W'(1);
        if (w_store_fire) begin
          r_store_addr  <= r_store_addr + r_store_step;
          r_stores_done <= r_stores_done + ADDR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_stream_engine.sv
// Directed bench for lsu_stream_engine with memory responders and a small accelerator model.
module tb_lsu_stream_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] load_base_addr = '0, load_stride = '0, load_count = '0;
  logic [31:0] store_base_addr = '0, store_stride = '0, store_count = '0;
  logic        busy, done, load_req, store_req;
  logic [31:0] load_addr, store_addr, store_data;
  logic [31:0] load_data;
  logic        load_complete, store_complete;
  logic        acc_in_valid, acc_in_ready, acc_out_valid, acc_out_ready;
  logic [31:0] acc_in_data, acc_out_data;

  always #5 clk = ~clk;

  lsu_stream_engine #(.ADDR_W(32), .DATA_W(32), .IN_DEPTH(4), .OUT_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .load_base_addr(load_base_addr), .load_stride(load_stride), .load_count(load_count),
    .store_base_addr(store_base_addr), .store_stride(store_stride), .store_count(store_count),
    .busy(busy), .done(done),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_complete(load_complete),
    .store_req(store_req), .store_addr(store_addr), .store_data(store_data),
    .store_complete(store_complete),
    .acc_in_valid(acc_in_valid), .acc_in_ready(acc_in_ready), .acc_in_data(acc_in_data),
    .acc_out_valid(acc_out_valid), .acc_out_ready(acc_out_ready), .acc_out_data(acc_out_data)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Memory responders: complete one cycle after a request is seen; load data = word index from 0x100, plus 1.
  logic [31:0] ld_log[$];
  logic [31:0] st_addr_log[$];
  logic [31:0] st_data_log[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      load_complete <= 1'b0;
      load_data     <= '0;
    end else if (load_complete) begin
      load_complete <= 1'b0;
    end else if (load_req) begin
      load_complete <= 1'b1;
      load_data     <= ((load_addr - 32'h100) >> 2) + 32'd1;
      ld_log.push_back(load_addr);
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      store_complete <= 1'b0;
    end else if (store_complete) begin
      store_complete <= 1'b0;
    end else if (store_req) begin
      store_complete <= 1'b1;
      st_addr_log.push_back(store_addr);
      st_data_log.push_back(store_data);
    end
  end

  // Accelerator: mode 0 passes each word through; mode 1 emits the sum of every 8 inputs.
  logic        acc_en = 1'b1;
  logic        acc_mode = 1'b0;
  logic        acc_have;
  logic [31:0] acc_val, acc_sum;
  int          acc_n;

  assign acc_in_ready  = acc_en && !acc_have;
  assign acc_out_valid = acc_have;
  assign acc_out_data  = acc_val;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_have <= 1'b0;
      acc_val  <= '0;
      acc_sum  <= '0;
      acc_n    <= 0;
    end else begin
      if (acc_out_valid && acc_out_ready) acc_have <= 1'b0;
      if (acc_in_valid && acc_in_ready) begin
        if (!acc_mode) begin
          acc_have <= 1'b1;
          acc_val  <= acc_in_data;
        end else if (acc_n == 7) begin
          acc_have <= 1'b1;
          acc_val  <= acc_sum + acc_in_data;
          acc_sum  <= '0;
          acc_n    <= 0;
        end else begin
          acc_sum <= acc_sum + acc_in_data;
          acc_n   <= acc_n + 1;
        end
      end
    end
  end

  int done_cnt = 0;
  int req_cycles = 0;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (load_req || store_req) req_cycles <= req_cycles + 1;
  end

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic clear_logs();
    ld_log.delete();
    st_addr_log.delete();
    st_data_log.delete();
  endtask

  task automatic launch(input logic [31:0] lb, input logic [31:0] ls, input logic [31:0] lc,
                        input logic [31:0] sb, input logic [31:0] ss, input logic [31:0] sc);
    @(negedge clk);
    load_base_addr  = lb;
    load_stride     = ls;
    load_count      = lc;
    store_base_addr = sb;
    store_stride    = ss;
    store_count     = sc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(nm, {31'd0, seen}, 32'd1);
  endtask

  typedef struct packed {
    logic [31:0] ld;
    logic [31:0] st;
    logic [31:0] sd;
  } vec_t;

  vec_t        t1[8];
  logic [31:0] t4[4];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int r0;
    bit seen;

    t1[0] = '{ld: 32'h100, st: 32'h200, sd: 32'd1};
    t1[1] = '{ld: 32'h104, st: 32'h204, sd: 32'd2};
    t1[2] = '{ld: 32'h108, st: 32'h208, sd: 32'd3};
    t1[3] = '{ld: 32'h10C, st: 32'h20C, sd: 32'd4};
    t1[4] = '{ld: 32'h110, st: 32'h210, sd: 32'd5};
    t1[5] = '{ld: 32'h114, st: 32'h214, sd: 32'd6};
    t1[6] = '{ld: 32'h118, st: 32'h218, sd: 32'd7};
    t1[7] = '{ld: 32'h11C, st: 32'h21C, sd: 32'd8};
    t4[0] = 32'hFFFF_FFF0;
    t4[1] = 32'hFFFF_FFFC;
    t4[2] = 32'h0000_0008;
    t4[3] = 32'h0000_0014;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_reqs", {30'd0, load_req, store_req}, 32'd0);
    check("rst_acc", {30'd0, acc_in_valid, acc_out_ready}, 32'd0);
    check("rst_load_addr", load_addr, 32'd0);
    check("rst_store_addr", store_addr, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Test 1: pass-through stream of 8 words
    clear_logs();
    d0 = done_cnt;
    launch(32'h100, 32'd1, 32'd8, 32'h200, 32'd1, 32'd8);
    wait_done("t1_done", 500);
    repeat (3) @(negedge clk);
    check("t1_done_pulses", done_cnt - d0, 32'd1);
    check("t1_nloads", ld_log.size(), 32'd8);
    check("t1_nstores", st_addr_log.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t1_load_addr[%0d]", i), qget(ld_log, i), t1[i].ld);
      check($sformatf("t1_store_addr[%0d]", i), qget(st_addr_log, i), t1[i].st);
      check($sformatf("t1_store_data[%0d]", i), qget(st_data_log, i), t1[i].sd);
    end

    // Test 2: 8 loads reduced to one stored sum
    clear_logs();
    acc_mode = 1'b1;
    d0 = done_cnt;
    launch(32'h100, 32'd1, 32'd8, 32'h400, 32'd1, 32'd1);
    wait_done("t2_done", 500);
    repeat (3) @(negedge clk);
    acc_mode = 1'b0;
    check("t2_done_pulses", done_cnt - d0, 32'd1);
    check("t2_nloads", ld_log.size(), 32'd8);
    check("t2_nstores", st_addr_log.size(), 32'd1);
    check("t2_store_addr", qget(st_addr_log, 0), 32'h400);
    check("t2_store_data", qget(st_data_log, 0), 32'd36);

    // Test 3: accelerator stalled, input FIFO fills then loads stop
    clear_logs();
    acc_en = 1'b0;
    launch(32'h100, 32'd1, 32'd8, 32'h200, 32'd1, 32'd8);
    repeat (20) @(negedge clk);
    check("t3_loads_while_stalled", ld_log.size(), 32'd4);
    check("t3_load_req_stalled", {31'd0, load_req}, 32'd0);
    check("t3_busy_stalled", {31'd0, busy}, 32'd1);
    acc_en = 1'b1;
    wait_done("t3_done", 500);
    repeat (3) @(negedge clk);
    check("t3_nstores", st_data_log.size(), 32'd8);
    check("t3_last_data", qget(st_data_log, 7), 32'd8);

    // Test 4: stride 3 with address wrap
    clear_logs();
    launch(32'hFFFF_FFF0, 32'd3, 32'd4, 32'h300, 32'd1, 32'd4);
    wait_done("t4_done", 500);
    repeat (3) @(negedge clk);
    check("t4_nloads", ld_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_load_addr[%0d]", i), qget(ld_log, i), t4[i]);
    check("t4_store_addr3", qget(st_addr_log, 3), 32'h30C);

    // Test 5: empty job
    clear_logs();
    r0 = req_cycles;
    d0 = done_cnt;
    launch(32'h100, 32'd1, 32'd0, 32'h200, 32'd1, 32'd0);
    check("t5_c1_busy", {31'd0, busy}, 32'd1);
    check("t5_c1_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    check("t5_c2_busy", {31'd0, busy}, 32'd0);
    check("t5_c2_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check("t5_c3_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    check("t5_no_req", req_cycles - r0, 32'd0);
    check("t5_done_pulses", done_cnt - d0, 32'd1);

    // Test 6: reset mid-job, then a clean job
    clear_logs();
    d0 = done_cnt;
    launch(32'h100, 32'd1, 32'd8, 32'h200, 32'd1, 32'd8);
    repeat (3) @(negedge clk);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (load_req) seen = 1'b1;
      else @(negedge clk);
    end
    check("t6_load_req_before_reset", {31'd0, seen}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("t6_rst_reqs", {30'd0, load_req, store_req}, 32'd0);
    check("t6_rst_busy_done", {30'd0, busy, done}, 32'd0);
    check("t6_rst_acc", {30'd0, acc_in_valid, acc_out_ready}, 32'd0);
    check("t6_rst_load_addr", load_addr, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_no_done_after_abort", done_cnt - d0, 32'd0);
    clear_logs();
    launch(32'h100, 32'd1, 32'd8, 32'h200, 32'd1, 32'd8);
    wait_done("t6_rerun_done", 500);
    repeat (3) @(negedge clk);
    check("t6_rerun_first_load", qget(ld_log, 0), 32'h100);
    check("t6_rerun_nstores", st_data_log.size(), 32'd8);
    check("t6_rerun_last_data", qget(st_data_log, 7), 32'd8);
    check("t6_rerun_last_addr", qget(st_addr_log, 7), 32'h21C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
